// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared frame constants, FSM state types and parity helper
//               for the uart_top transceiver.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_e;

  // Even parity: the parity bit makes the total count of ones even
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_if
// Description : Byte/serial bundle between a UART user and uart_top.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_if;
  import uart_pkg::*;

  logic                 wr_data;
  logic [DATA_BITS-1:0] data;
  logic                 rx;
  logic                 baud_clk_t;
  logic                 baud_clk_r;
  logic                 tx;
  logic                 donet;
  logic                 error;
  logic                 doner;
  logic [DATA_BITS-1:0] rx_data;

  modport master (
    output wr_data, data, rx,
    input  baud_clk_t, baud_clk_r, tx, donet, error, doner, rx_data
  );

  modport slave (
    input  wr_data, data, rx,
    output baud_clk_t, baud_clk_r, tx, donet, error, doner, rx_data
  );

endinterface
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen
// Description : Free-running divider producing a one-cycle strobe every DIV
//               clock cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
  parameter int DIV = 434
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic strobe_o
);

  localparam int            CW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] c_LAST_CNT = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          strobe_q, strobe_d;

  // Wrap at the divider boundary and flag the strobe on that cycle
  always_comb begin
    strobe_d = (cnt_q == c_LAST_CNT);
    cnt_d    = strobe_d ? '0 : cnt_q + 1'b1;
  end

  // Counter and registered strobe
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  assign strobe_o = strobe_q;

endmodule
`default_nettype wire

// File: rtl/uart_top.sv
`default_nettype none
// ============================================================================
// Module      : uart_top
// Description : UART transceiver, 8E1 frames, 16x oversampled receiver with
//               optional internal loopback of the transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_top
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int LOOPBACK = 1
) (
  input  logic  clk1,
  input  logic  rst,
  uart_if.slave bus
);

  localparam int TX_DIV = CLK_FREQ / BAUD;
  localparam int RX_DIV = CLK_FREQ / (OVERSAMPLE * BAUD);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam int TICK_W = $clog2(OVERSAMPLE);

  localparam logic [BIT_W-1:0]  c_LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic [TICK_W-1:0] c_LAST_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] c_MID_TICK  = TICK_W'(MID_SAMPLE - 1);

  logic tx_tick, rx_tick, rx_line;

  tx_state_e            tx_state_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 tx_par_q, tx_q, donet_q;
  logic [BIT_W-1:0]     tx_bit_q;

  rx_state_e            rx_state_q;
  logic [DATA_BITS-1:0] rx_shift_q, rx_data_q;
  logic [TICK_W-1:0]    rx_tick_q;
  logic [BIT_W-1:0]     rx_bit_q;
  logic                 rx_par_q, error_q, doner_q;

  uart_baud_gen #(.DIV(TX_DIV)) u_tx_baud (.clk_i(clk1), .rst_ni(rst), .strobe_o(tx_tick));
  uart_baud_gen #(.DIV(RX_DIV)) u_rx_baud (.clk_i(clk1), .rst_ni(rst), .strobe_o(rx_tick));

  // The receiver listens to its own transmitter in loopback, otherwise to a
  // resynchronised copy of the external line (reset to idle-high)
  generate
    if (LOOPBACK != 0) begin : g_loopback
      assign rx_line = tx_q;
    end else begin : g_rx_sync
      logic [1:0] sync_q;
      // Two-flop synchroniser for the asynchronous serial input
      always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) sync_q <= 2'b11;
        else      sync_q <= {sync_q[0], bus.rx};
      end
      assign rx_line = sync_q[1];
    end
  endgenerate

  // TX framer: one frame bit per TX strobe; a pending request at the end of
  // the stop bit starts the next frame without an idle bit
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      tx_state_q <= TX_IDLE;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_bit_q   <= '0;
      tx_q       <= 1'b1;
      donet_q    <= 1'b0;
    end else begin
      donet_q <= 1'b0;
      if (tx_tick) begin
        case (tx_state_q)
          TX_IDLE, TX_STOP: begin
            if (tx_state_q == TX_STOP) donet_q <= 1'b1;
            if (bus.wr_data) begin
              tx_shift_q <= bus.data;
              tx_par_q   <= even_parity(bus.data);
              tx_q       <= 1'b0;
              tx_state_q <= TX_START;
            end else begin
              tx_q       <= 1'b1;
              tx_state_q <= TX_IDLE;
            end
          end
          TX_START: begin
            tx_q       <= tx_shift_q[0];
            tx_shift_q <= {1'b0, tx_shift_q[DATA_BITS-1:1]};
            tx_bit_q   <= '0;
            tx_state_q <= TX_DATA;
          end
          TX_DATA: begin
            if (tx_bit_q == c_LAST_BIT) begin
              tx_q       <= tx_par_q;
              tx_state_q <= TX_PARITY;
            end else begin
              tx_q       <= tx_shift_q[0];
              tx_shift_q <= {1'b0, tx_shift_q[DATA_BITS-1:1]};
              tx_bit_q   <= tx_bit_q + 1'b1;
            end
          end
          TX_PARITY: begin
            tx_q       <= 1'b1;
            tx_state_q <= TX_STOP;
          end
          default: begin
            tx_q       <= 1'b1;
            tx_state_q <= TX_IDLE;
          end
        endcase
      end
    end
  end

  // RX deframer: start validated at bit centre, then one sample per 16 ticks
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      rx_state_q <= RX_IDLE;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      rx_data_q  <= '0;
      error_q    <= 1'b0;
      doner_q    <= 1'b0;
    end else begin
      doner_q <= 1'b0;
      if (rx_tick) begin
        case (rx_state_q)
          RX_IDLE: begin
            if (!rx_line) begin
              rx_tick_q  <= '0;
              rx_state_q <= RX_START;
            end
          end
          RX_START: begin
            if (rx_tick_q == c_MID_TICK) begin
              rx_tick_q  <= '0;
              rx_bit_q   <= '0;
              rx_state_q <= rx_line ? RX_IDLE : RX_DATA;
            end else begin
              rx_tick_q <= rx_tick_q + 1'b1;
            end
          end
          RX_DATA: begin
            if (rx_tick_q == c_LAST_TICK) begin
              rx_tick_q  <= '0;
              rx_shift_q <= {rx_line, rx_shift_q[DATA_BITS-1:1]};
              rx_bit_q   <= rx_bit_q + 1'b1;
              if (rx_bit_q == c_LAST_BIT) rx_state_q <= RX_PARITY;
            end else begin
              rx_tick_q <= rx_tick_q + 1'b1;
            end
          end
          RX_PARITY: begin
            if (rx_tick_q == c_LAST_TICK) begin
              rx_tick_q  <= '0;
              rx_par_q   <= rx_line;
              rx_state_q <= RX_STOP;
            end else begin
              rx_tick_q <= rx_tick_q + 1'b1;
            end
          end
          RX_STOP: begin
            if (rx_tick_q == c_LAST_TICK) begin
              rx_tick_q  <= '0;
              rx_data_q  <= rx_shift_q;
              error_q    <= (rx_par_q != even_parity(rx_shift_q)) | ~rx_line;
              doner_q    <= 1'b1;
              rx_state_q <= RX_IDLE;
            end else begin
              rx_tick_q <= rx_tick_q + 1'b1;
            end
          end
          default: rx_state_q <= RX_IDLE;
        endcase
      end
    end
  end

  assign bus.baud_clk_t = tx_tick;
  assign bus.baud_clk_r = rx_tick;
  assign bus.tx         = tx_q;
  assign bus.donet      = donet_q;
  assign bus.error      = error_q;
  assign bus.doner      = doner_q;
  assign bus.rx_data    = rx_data_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_top
// Description : Self-checking bench for uart_top: one loopback instance and
//               one external-line instance against a bit-level frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_top;

  localparam int TDIV  = 434;
  localparam int RDIV  = 27;
  localparam int FRAME = 11 * TDIV;

  typedef struct {
    logic [7:0] d;
    logic       e;
    int         s;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_if bus_lb ();
  uart_if bus_ex ();

  uart_top #(.CLK_FREQ(50_000_000), .BAUD(115200), .LOOPBACK(1)) u_lb (
    .clk1(clk), .rst(rst), .bus(bus_lb)
  );
  uart_top #(.CLK_FREQ(50_000_000), .BAUD(115200), .LOOPBACK(0)) u_ex (
    .clk1(clk), .rst(rst), .bus(bus_ex)
  );

  int tests = 0;
  int fails = 0;
  int cyc;

  // Rising edges since reset release
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  logic       tx_w[2], dt_w[2], dr_w[2], er_w[2], st_w[2], sr_w[2], wr_w[2];
  logic [7:0] rd_w[2], da_w[2];
  assign tx_w[0] = bus_lb.tx;         assign tx_w[1] = bus_ex.tx;
  assign dt_w[0] = bus_lb.donet;      assign dt_w[1] = bus_ex.donet;
  assign dr_w[0] = bus_lb.doner;      assign dr_w[1] = bus_ex.doner;
  assign er_w[0] = bus_lb.error;      assign er_w[1] = bus_ex.error;
  assign st_w[0] = bus_lb.baud_clk_t; assign st_w[1] = bus_ex.baud_clk_t;
  assign sr_w[0] = bus_lb.baud_clk_r; assign sr_w[1] = bus_ex.baud_clk_r;
  assign wr_w[0] = bus_lb.wr_data;    assign wr_w[1] = bus_ex.wr_data;
  assign rd_w[0] = bus_lb.rx_data;    assign rd_w[1] = bus_ex.rx_data;
  assign da_w[0] = bus_lb.data;       assign da_w[1] = bus_ex.data;

  // Model state
  int         idx[2];
  logic [10:0] fr[2];
  logic       donet_exp[2];
  logic [7:0] exp_rxd[2];
  logic       exp_err[2];
  exp_t       q_lb[$];
  exp_t       q_ex[$];
  int         n_donet = 0;
  int         n_doner[2] = '{0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: got %0h, expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  // Received-frame check against the queue of frames put on the line
  task automatic rx_cmp(input int d, input logic dr, input logic [7:0] rd, input logic er);
    exp_t e;
    logic have;
    have = (d == 0) ? (q_lb.size() > 0) : (q_ex.size() > 0);
    if (have) e = (d == 0) ? q_lb[0] : q_ex[0];
    if (dr) begin
      n_doner[d]++;
      if (!have) begin
        chk("unexpected_doner", {31'd0, dr}, 32'd0);
      end else begin
        if (d == 0) void'(q_lb.pop_front()); else void'(q_ex.pop_front());
        chk("rx_data", {24'd0, rd}, {24'd0, e.d});
        chk("rx_error", {31'd0, er}, {31'd0, e.e});
        chk("doner_window", {31'd0, (cyc - e.s >= 10 * TDIV) && (cyc - e.s <= FRAME)}, 32'd1);
        exp_rxd[d] = e.d;
        exp_err[d] = e.e;
      end
    end else begin
      chk("rx_data_hold", {24'd0, rd}, {24'd0, exp_rxd[d]});
      chk("rx_error_hold", {31'd0, er}, {31'd0, exp_err[d]});
      if (have && (cyc - e.s > FRAME + 40)) begin
        chk("missing_doner", {31'd0, dr}, 32'd1);
        if (d == 0) void'(q_lb.pop_front()); else void'(q_ex.pop_front());
      end
    end
  endtask

  // Per-cycle compare, then advance the frame model across the next edge
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        chk("rst_tx", {31'd0, tx_w[d]}, 32'd1);
        chk("rst_donet", {31'd0, dt_w[d]}, 32'd0);
        chk("rst_doner", {31'd0, dr_w[d]}, 32'd0);
        chk("rst_error", {31'd0, er_w[d]}, 32'd0);
        chk("rst_rx_data", {24'd0, rd_w[d]}, 32'd0);
        chk("rst_strobes", {30'd0, st_w[d], sr_w[d]}, 32'd0);
        idx[d] = -1;
        donet_exp[d] = 1'b0;
        exp_rxd[d] = 8'h00;
        exp_err[d] = 1'b0;
      end
      q_lb.delete();
      q_ex.delete();
    end else begin
      for (int d = 0; d < 2; d++) begin
        chk("baud_clk_t", {31'd0, st_w[d]}, {31'd0, (cyc > 0) && (cyc % TDIV == 0)});
        chk("baud_clk_r", {31'd0, sr_w[d]}, {31'd0, (cyc > 0) && (cyc % RDIV == 0)});
        chk("tx", {31'd0, tx_w[d]}, {31'd0, (idx[d] < 0) ? 1'b1 : fr[d][idx[d]]});
        chk("donet", {31'd0, dt_w[d]}, {31'd0, donet_exp[d]});
        if (d == 0 && dt_w[0]) n_donet++;
        rx_cmp(d, dr_w[d], rd_w[d], er_w[d]);
        donet_exp[d] = 1'b0;
        if (cyc > 0 && cyc % TDIV == 0) begin
          if (idx[d] == 10) donet_exp[d] = 1'b1;
          if (idx[d] < 0 || idx[d] == 10) begin
            if (wr_w[d]) begin
              fr[d]  = {1'b1, ^da_w[d], da_w[d], 1'b0};
              idx[d] = 0;
              if (d == 0) q_lb.push_back('{d: da_w[0], e: 1'b0, s: cyc + 1});
            end else begin
              idx[d] = -1;
            end
          end else begin
            idx[d]++;
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // One frame from the loopback instance; seq holds the line at each bit centre
  task automatic lb_frame(input logic [7:0] d, output logic [10:0] seq);
    int t, n0, r0;
    n0 = n_donet;
    r0 = n_doner[0];
    seq = '0;
    bus_lb.data = d;
    bus_lb.wr_data = 1'b1;
    t = 0;
    while (bus_lb.tx !== 1'b0 && t < 2 * TDIV) begin step(1); t++; end
    chk("tx_start_latency", {31'd0, t <= TDIV + 2}, 32'd1);
    bus_lb.wr_data = 1'b0;
    bus_lb.data = ~d;
    step(TDIV / 2);
    seq[0] = bus_lb.tx;
    for (int i = 1; i < 11; i++) begin step(TDIV); seq[i] = bus_lb.tx; end
    step(300);
    chk("frame_donet_count", n_donet - n0, 32'd1);
    chk("frame_doner_count", n_doner[0] - r0, 32'd1);
  endtask

  task automatic send_ext(input logic [7:0] d, input logic p, input logic s);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    q_ex.push_back('{d: d, e: (p != ^d) | ~s, s: cyc});
    for (int i = 0; i < 11; i++) begin bus_ex.rx = f[i]; step(TDIV); end
    bus_ex.rx = 1'b1;
    step(500);
  endtask

  task automatic measure(input logic which, output int per);
    int n, t0;
    n = 0;
    per = 0;
    while ((which ? bus_lb.baud_clk_r : bus_lb.baud_clk_t) !== 1'b1 && n < 1000) begin step(1); n++; end
    t0 = cyc;
    step(1);
    n = 0;
    while ((which ? bus_lb.baud_clk_r : bus_lb.baud_clk_t) !== 1'b1 && n < 1000) begin step(1); n++; end
    per = cyc - t0;
  endtask

  initial begin
    logic [10:0] seq;
    int per, n0, r0, r1;
    bus_lb.wr_data = 1'b0; bus_lb.data = 8'h00; bus_lb.rx = 1'b1;
    bus_ex.wr_data = 1'b0; bus_ex.data = 8'h00; bus_ex.rx = 1'b1;
    rst = 1'b0;
    step(3);
    chk("reset_tx", {31'd0, bus_lb.tx}, 32'd1);
    chk("reset_outputs", {27'd0, bus_lb.donet, bus_lb.doner, bus_lb.error, bus_lb.baud_clk_t, bus_lb.baud_clk_r}, 32'd0);
    chk("reset_rx_data", {24'd0, bus_lb.rx_data}, 32'd0);
    rst = 1'b1;

    measure(1'b0, per);
    chk("baud_t_period", per, TDIV);
    measure(1'b1, per);
    chk("baud_r_period", per, RDIV);

    fork
      begin
        lb_frame(8'hAA, seq);
        chk("tx_seq_AA", {21'd0, seq}, {21'd0, 11'b10101010100});
        lb_frame(8'h07, seq);
        chk("tx_parity_07", {31'd0, seq[9]}, 32'd1);
        chk("lb_rx_data_07", {24'd0, bus_lb.rx_data}, 32'h07);
        chk("lb_error_07", {31'd0, bus_lb.error}, 32'd0);
        // back-to-back: three frames while the request stays high
        n0 = n_donet;
        r0 = n_doner[0];
        bus_lb.data = 8'h55;
        bus_lb.wr_data = 1'b1;
        per = 0;
        while (bus_lb.tx !== 1'b0 && per < 2 * TDIV) begin step(1); per++; end
        step(2 * FRAME + 2000);
        bus_lb.wr_data = 1'b0;
        step(FRAME - 2000 + 300);
        chk("b2b_donet_count", n_donet - n0, 32'd3);
        chk("b2b_doner_count", n_doner[0] - r0, 32'd3);
        chk("b2b_rx_data", {24'd0, bus_lb.rx_data}, 32'h55);
        for (int i = 0; i < 3; i++) lb_frame(8'($urandom), seq);
      end
      begin
        send_ext(8'h01, 1'b0, 1'b1);
        chk("ext_parity_error", {31'd0, bus_ex.error}, 32'd1);
        chk("ext_parity_rx_data", {24'd0, bus_ex.rx_data}, 32'h01);
        send_ext(8'hA5, 1'b0, 1'b0);
        chk("ext_stop_error", {31'd0, bus_ex.error}, 32'd1);
        send_ext(8'h3C, 1'b0, 1'b1);
        chk("ext_good_error", {31'd0, bus_ex.error}, 32'd0);
        chk("ext_good_rx_data", {24'd0, bus_ex.rx_data}, 32'h3C);
        r1 = n_doner[1];
        bus_ex.rx = 1'b0;
        step(100);
        bus_ex.rx = 1'b1;
        step(600);
        chk("glitch_no_doner", n_doner[1] - r1, 32'd0);
        for (int i = 0; i < 3; i++) begin
          logic [7:0] d;
          logic p, s;
          d = 8'($urandom);
          p = (^d) ^ ($urandom_range(0, 3) == 0);
          s = ($urandom_range(0, 3) != 0);
          send_ext(d, p, s);
        end
      end
    join

    // Reset in the middle of a transmitted frame
    bus_lb.data = 8'hC3;
    bus_lb.wr_data = 1'b1;
    per = 0;
    while (bus_lb.tx !== 1'b0 && per < 2 * TDIV) begin step(1); per++; end
    bus_lb.wr_data = 1'b0;
    step(2000);
    chk("pre_reset_in_frame", {31'd0, per < 2 * TDIV}, 32'd1);
    n0 = n_donet;
    r0 = n_doner[0];
    r1 = n_doner[1];
    rst = 1'b0;
    #1;
    chk("midrst_tx", {31'd0, bus_lb.tx}, 32'd1);
    chk("midrst_pulses", {30'd0, bus_lb.donet, bus_lb.doner}, 32'd0);
    step(3);
    rst = 1'b1;
    step(FRAME + 800);
    chk("midrst_no_donet", n_donet - n0, 32'd0);
    chk("midrst_no_doner", (n_doner[0] - r0) + (n_doner[1] - r1), 32'd0);
    chk("midrst_tx_idle", {31'd0, bus_lb.tx}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #(150000 * 10);
    $display("FAIL watchdog: bench did not reach its summary, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
